// File: rtl/router_fifo_pkg.sv
// ----------------------------------------------------------------------------
// router_fifo_pkg
// Shared router definitions used by the router FIFO:
//   ROUTER_WIDTH / ROUTER_DEPTH : default byte width and FIFO depth
//   HDR_LEN_MSB / HDR_LEN_LSB   : payload-length field of a header byte
//   HDR_ADDR_MSB / HDR_ADDR_LSB : destination-address field of a header byte
//   PKT_CNT_W                   : width of the read-side packet byte counter
//   pkt_count_load()            : bytes still to read after a header
//                                 (payload length plus the parity byte)
// ----------------------------------------------------------------------------
package router_fifo_pkg;

    localparam int ROUTER_WIDTH = 8;
    localparam int ROUTER_DEPTH = 16;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam int PKT_CNT_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Counter load value for a header: payload bytes plus one parity byte.
    // A length of 63 wraps to 0 in the 6-bit counter.
    function automatic logic [PKT_CNT_W-1:0] pkt_count_load(
        input logic [PKT_CNT_W-1:0] hdr_len
    );
        return hdr_len + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/router_fifo.sv
// ----------------------------------------------------------------------------
// router_fifo
// Per-destination packet FIFO of the router. Each entry stores the byte and a
// header flag. Reads have one clock of latency into a registered data_out.
// A packet counter tracks how many bytes of the current packet remain to be
// read so that pkt_busy stays high from the header read to the parity read.
//
// Parameters: DEPTH (power of two, >= 4), WIDTH (byte width, >= 8)
// Ports:
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   soft_reset  synchronous flush (overrides concurrent read/write)
//   write_enb   write request, ignored while full
//   read_enb    read request, ignored while empty
//   lfd_state   header flag stored with data_in
//   data_in     byte to store
//   data_out    registered read data, holds when no read occurs
//   full        no free entry (combinational from pointers)
//   empty       no stored entry (combinational from pointers)
//   pkt_busy    packet readout in progress
//   fifo_count  occupancy, present only with ROUTER_FIFO_OCCUPANCY_EN defined
// ----------------------------------------------------------------------------
module router_fifo
    import router_fifo_pkg::*;
#(
    parameter int DEPTH = ROUTER_DEPTH,
    parameter int WIDTH = ROUTER_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_count
`else
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [PKT_CNT_W-1:0] CNT_ZERO = {PKT_CNT_W{1'b0}};
    localparam logic [PKT_CNT_W-1:0] CNT_ONE  = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

    // Storage is not reset: entries are only visible between the pointers.
    logic [WIDTH:0]           mem_r [DEPTH];

    logic [AW:0]              wr_ptr_r, rd_ptr_r;
    logic [WIDTH-1:0]         data_out_r;
    logic [PKT_CNT_W-1:0]     pkt_cnt_r;
    logic                     pkt_busy_r;

    logic                     full_s, empty_s, wr_ok_s, rd_ok_s;
    logic [WIDTH:0]           rd_entry_s;
    logic [PKT_CNT_W-1:0]     cnt_dec_s;
    logic [AW:0]              wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [WIDTH-1:0]         data_out_nxt_s;
    logic [PKT_CNT_W-1:0]     pkt_cnt_nxt_s;
    logic                     pkt_busy_nxt_s;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign full     = full_s;
    assign empty    = empty_s;
    assign data_out = data_out_r;
    assign pkt_busy = pkt_busy_r;

`ifdef ROUTER_FIFO_OCCUPANCY_EN
    // Pointer difference is the occupancy; modulo arithmetic handles wrap.
    assign fifo_count = wr_ptr_r - rd_ptr_r;
`else
    // Occupancy output not built in this configuration.
`endif

    // Next-state logic for pointers, read data and packet tracking.
    always_comb begin
        wr_ok_s        = write_enb & ~full_s & ~soft_reset;
        rd_ok_s        = read_enb & ~empty_s & ~soft_reset;
        rd_entry_s     = mem_r[rd_ptr_r[AW-1:0]];
        cnt_dec_s      = pkt_cnt_r - CNT_ONE;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        data_out_nxt_s = data_out_r;
        pkt_cnt_nxt_s  = pkt_cnt_r;
        pkt_busy_nxt_s = pkt_busy_r;

        if (soft_reset) begin
            wr_ptr_nxt_s   = {(AW+1){1'b0}};
            rd_ptr_nxt_s   = {(AW+1){1'b0}};
            data_out_nxt_s = {WIDTH{1'b0}};
            pkt_cnt_nxt_s  = CNT_ZERO;
            pkt_busy_nxt_s = 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end

            if (rd_ok_s) begin
                rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
                data_out_nxt_s = rd_entry_s[WIDTH-1:0];
                if (rd_entry_s[WIDTH]) begin
                    // A header always restarts tracking, even mid-packet.
                    pkt_cnt_nxt_s  = pkt_count_load(rd_entry_s[HDR_LEN_MSB:HDR_LEN_LSB]);
                    pkt_busy_nxt_s = 1'b1;
                end else if (pkt_cnt_r != CNT_ZERO) begin
                    pkt_cnt_nxt_s  = cnt_dec_s;
                    pkt_busy_nxt_s = (cnt_dec_s != CNT_ZERO);
                end else begin
                    pkt_cnt_nxt_s  = pkt_cnt_r;
                    pkt_busy_nxt_s = pkt_busy_r;
                end
            end else begin
                rd_ptr_nxt_s   = rd_ptr_r;
                data_out_nxt_s = data_out_r;
            end
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            data_out_r <= {WIDTH{1'b0}};
            pkt_cnt_r  <= CNT_ZERO;
            pkt_busy_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            data_out_r <= data_out_nxt_s;
            pkt_cnt_r  <= pkt_cnt_nxt_s;
            pkt_busy_r <= pkt_busy_nxt_s;
        end
    end

    // Storage write port.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// ----------------------------------------------------------------------------
// tb_router_fifo
// Directed bench for router_fifo. A queue holds the entries the bench expects
// the FIFO to contain; accepted writes push, accepted reads pop and become
// the expected data_out. Packet-counter and pkt_busy expectations are derived
// from the popped header flag/length.
// ----------------------------------------------------------------------------
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clock      = 1'b0;
    logic             resetn     = 1'b0;
    logic             soft_reset = 1'b0;
    logic             write_enb  = 1'b0;
    logic             read_enb   = 1'b0;
    logic             lfd_state  = 1'b0;
    logic [WIDTH-1:0] data_in    = 8'h00;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, pkt_busy;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    logic [4:0]       fifo_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [8:0] m_q[$];
    logic [7:0] m_dout = 8'h00;
    logic [5:0] m_cnt  = 6'd0;
    logic       m_busy = 1'b0;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        ,
        .fifo_count (fifo_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
        chk("full",     {31'd0, full},     {31'd0, (m_q.size() == DEPTH)});
        chk("empty",    {31'd0, empty},    {31'd0, (m_q.size() == 0)});
        chk("pkt_busy", {31'd0, pkt_busy}, {31'd0, m_busy});
`ifdef ROUTER_FIFO_OCCUPANCY_EN
        chk("fifo_count", {27'd0, fifo_count}, m_q.size());
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = 8'h00;
        m_cnt  = 6'd0;
        m_busy = 1'b0;
    endtask

    // One clock: drive, apply edge to the expectation model, then check.
    task automatic cycle(input logic wr, input logic rd, input logic lfd,
                         input logic [7:0] din, input logic srst);
        logic       pre_full, pre_empty;
        logic [8:0] e;
        write_enb  = wr;
        read_enb   = rd;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = srst;
        @(posedge clock);
        pre_full  = (m_q.size() == DEPTH);
        pre_empty = (m_q.size() == 0);
        if (srst) begin
            model_reset();
        end else begin
            if (rd && !pre_empty) begin
                e = m_q.pop_front();
                m_dout = e[7:0];
                if (e[8]) begin
                    m_cnt  = e[7:2] + 6'd1;
                    m_busy = 1'b1;
                end else if (m_cnt != 6'd0) begin
                    m_cnt  = m_cnt - 6'd1;
                    m_busy = (m_cnt != 6'd0);
                end
            end
            if (wr && !pre_full) m_q.push_back({lfd, din});
        end
        #1;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] d;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        resetn = 1'b1;

        // Header 8'h22 (8 payload bytes) + payload + parity, then read all 10
        par = 8'h22;
        cycle(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = 8'h30 + 8'(i);
            par = par ^ d;
            cycle(1'b1, 1'b0, 1'b0, d, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, par, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            if (i == 0) begin
                chk("hdr_data", {24'd0, data_out}, 32'h22);
                chk("hdr_busy", {31'd0, pkt_busy}, 32'd1);
            end
            if (i == 8) chk("last_payload_busy", {31'd0, pkt_busy}, 32'd1);
            if (i == 9) begin
                chk("parity_data", {24'd0, data_out}, {24'd0, par});
                chk("parity_busy_clear", {31'd0, pkt_busy}, 32'd0);
            end
        end
        chk("pkt_end_empty", {31'd0, empty}, 32'd1);

        // Fill to full, overflow write dropped, read back in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'h01 + 8'(i * 7), 1'b0);
        chk("full_after_16", {31'd0, full}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
        chk("full_after_overflow", {31'd0, full}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("order", {24'd0, data_out}, {24'd0, 8'h01 + 8'(i * 7)});
        end
        chk("drained_empty", {31'd0, empty}, 32'd1);

        // Full FIFO: simultaneous read and write -> read only
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'hBB, 1'b0);
        chk("full_rw_full", {31'd0, full}, 32'd0);
        chk("full_rw_data", {24'd0, data_out}, 32'h80);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("full_rw_last", {24'd0, data_out}, 32'h8F);
        chk("full_rw_empty", {31'd0, empty}, 32'd1);

        // Empty FIFO: simultaneous read and write -> write only
        cycle(1'b1, 1'b1, 1'b0, 8'hCC, 1'b0);
        chk("empty_rw_hold", {24'd0, data_out}, 32'h8F);
        chk("empty_rw_empty", {31'd0, empty}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_rw_read", {24'd0, data_out}, 32'hCC);

        // Partial packet flushed by soft_reset (concurrent write ignored)
        cycle(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h41, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h42, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("partial_busy", {31'd0, pkt_busy}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        chk("srst_empty", {31'd0, empty}, 32'd1);
        chk("srst_busy", {31'd0, pkt_busy}, 32'd0);
        chk("srst_data", {24'd0, data_out}, 32'h00);
        par = 8'h0D;
        cycle(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 8'h60 + 8'(i);
            par = par ^ d;
            cycle(1'b1, 1'b0, 1'b0, d, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, par, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_srst_busy", {31'd0, pkt_busy}, 32'd0);
        chk("post_srst_parity", {24'd0, data_out}, {24'd0, par});

        // Asynchronous reset between edges during a packet read
        cycle(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h71, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h72, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        read_enb = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_data", {24'd0, data_out}, 32'h00);
        chk("async_busy", {31'd0, pkt_busy}, 32'd0);
        check_outputs();
        read_enb = 1'b0;
        @(posedge clock);
        #1;
        check_outputs();
        resetn = 1'b1;

        // First write after reset is taken per its own header flag
        cycle(1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_reset_data", {24'd0, data_out}, 32'h55);
        chk("post_reset_busy", {31'd0, pkt_busy}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_read_hold", {24'd0, data_out}, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries; power of two, minimum 4.
REQ-002 Parameter WIDTH, default 8, data byte width; each entry stores WIDTH+1 bits (header flag plus byte).
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port resetn  input  1  asynchronous active-low reset.
REQ-005 Port soft_reset  input  1  synchronous active-high flush from sync block timeout.
REQ-006 Port write_enb  input  1  write request from sync block.
REQ-007 Port read_enb  input  1  read request from destination.
REQ-008 Port lfd_state  input  1  high when data_in is a header byte; stored with the byte.
REQ-009 Port data_in  input  WIDTH  byte from router_reg data_out.
REQ-010 Port data_out  output  WIDTH  registered read data.
REQ-011 Port full  output  1  no free entry.
REQ-012 Port empty  output  1  no stored entry.
REQ-013 Port pkt_busy  output  1  high while a packet is being read out (header seen, bytes remaining).

Function
REQ-014 Write: on rising edge with write_enb=1 and full=0, store {lfd_state,data_in} at write pointer and advance it; with full=1, discard the write.
REQ-015 Read: on rising edge with read_enb=1 and empty=0, load data_out with the byte at read pointer and advance it; read latency is one clock.
REQ-016 No read or an empty read: data_out holds its previous value.
REQ-017 Pointers are log2(DEPTH)+1 bits; wrap from DEPTH-1 to 0 toggles MSB.
REQ-018 empty = pointers equal; full = MSBs differ and lower bits equal; both combinational from registered pointers.
REQ-019 Simultaneous read and write with empty=1: write accepted, read ignored, data_out unchanged.
REQ-020 Simultaneous read and write with full=1: read accepted, write discarded (full sampled at same edge).
REQ-021 Simultaneous read and write otherwise: both accepted, occupancy unchanged.
REQ-022 Packet counter (6 bits): on reading an entry with header flag set, load byte[7:2]+1 (payload plus parity) and set pkt_busy.
REQ-023 On reading a non-header entry with counter nonzero, decrement; when counter reaches 0, clear pkt_busy on the same edge.
REQ-024 A header read while pkt_busy=1 reloads the counter from the new header (aborted packet).
REQ-025 soft_reset=1 at a rising edge: pointers to 0, counter to 0, pkt_busy=0, data_out=0; concurrent read/write ignored.

Reset
REQ-026 resetn=0 asynchronously forces pointers=0, counter=0, data_out=0, pkt_busy=0, so empty=1 and full=0.
REQ-027 Storage array contents need not be reset; they are unreachable while empty.
REQ-028 Reset deassertion mid-packet restarts cleanly; the first post-reset write is treated per its lfd_state.

Configuration
REQ-029 Macro ROUTER_FIFO_OCCUPANCY_EN defined: add output fifo_count, width log2(DEPTH)+1, equal to write pointer minus read pointer, 0 on reset/soft_reset.
REQ-030 Macro undefined: fifo_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared router package holds WIDTH, DEPTH defaults, header field positions (length [7:2], address [1:0]) and the counter width.
REQ-032 No sub-module; storage array, pointer logic and packet counter are in router_fifo.

Verification
REQ-033 Reset, write header 8'h22 (lfd=1) plus 8 payload bytes plus parity, then read 10 -> data_out matches each byte one clock after read_enb, pkt_busy high from header read until parity read, empty=1 at end.
REQ-034 Write 16 bytes with no reads -> full=1 after 16th write; 17th write 8'hAA discarded; 16 reads return original order, no 8'hAA.
REQ-035 Full FIFO, assert read_enb and write_enb together -> one read, write dropped, full falls to 0.
REQ-036 Empty FIFO, assert both together -> write stored, data_out unchanged, empty=0 next cycle.
REQ-037 Half-written packet, pulse soft_reset -> empty=1, pkt_busy=0, data_out=0 next edge; subsequent packet reads correctly.
REQ-038 Assert resetn=0 between clock edges mid-read -> outputs cleared immediately without a clock edge; with ROUTER_FIFO_OCCUPANCY_EN, fifo_count=0.
